pc_fetch_unit: RTL

//   Instruction-fetch stage. Holds the program counter, requests instructions

---
 rtl/pc_fetch_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch stage: PC, imem req/ack, decode valid/ready
// A request already issued to memory is always waited out; redirects only retarget pc.
module pc_fetch_unit #(
  parameter int            N        = 32,
  parameter logic [N-1:0]  RESET_PC = '0,
  parameter int            INCR     = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic [31:0]  dec_instr,
  output logic [N-1:0] dec_pc,
  output logic [N-1:0] dec_pc_plus4
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [N-1:0] INCR_V = N'(INCR);

  logic [1:0]   state;
  logic [N-1:0] pc;
  logic [N-1:0] drain_addr;
  logic [N-1:0] redirect_tgt;
  logic         unused_redirect_lsbs;

  assign redirect_tgt         = {redirect_pc[N-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req     = ((state == S_REQ) || (state == S_DRAIN)) && !reset;
  // DRAIN keeps presenting the squashed address until memory acknowledges it.
  assign imem_addr    = (state == S_DRAIN) ? drain_addr : pc;
  assign dec_pc_plus4 = dec_pc + INCR_V;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drain_addr <= '0;
      dec_valid  <= 1'b0;
      dec_instr  <= '0;
      dec_pc     <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              pc <= redirect_tgt;
            end else begin
              dec_instr <= imem_rdata;
              dec_pc    <= pc;
              dec_valid <= 1'b1;
              pc        <= pc + INCR_V;
              state     <= S_HOLD;
            end
          end else if (redirect) begin
            drain_addr <= pc;
            pc         <= redirect_tgt;
            state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (redirect) begin
            pc <= redirect_tgt;
          end
          if (imem_ack) begin
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          // A redirect flushes the held word even if decode accepts it this cycle.
          if (redirect) begin
            dec_valid <= 1'b0;
            pc        <= redirect_tgt;
            state     <= S_REQ;
          end else if (dec_ready) begin
            dec_valid <= 1'b0;
            state     <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule
